// File: rtl/sm_const_mult_pipe_if.sv
// Streaming port bundle for sm_const_mult_pipe.
//   in_valid/in_ready/in_data    : operand stream (sign-magnitude, WIDTH bits)
//   out_valid/out_ready/out_data : product stream (sign-magnitude, WIDTH bits)
//   out_sat                      : qualifies out_data, magnitude was clamped
// master = producer/consumer side (testbench or neighbouring stages),
// slave  = the multiplier itself.
interface sm_const_mult_pipe_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_sat;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );
endinterface

// File: rtl/sm_const_mult_pipe.sv
// Pipelined sign-magnitude constant multiplier.
//   out = sign(in) * sum_{k : COEF_MASK[k]} (|in| >> k)
// Terms are spread over STAGES register stages (term k lives in stage
// k*STAGES/WIDTH); each stage carries the running sum, the sign and the
// operand magnitude. The whole pipe advances together when the output slot
// is free or being consumed, so latency is STAGES cycles and throughput is
// one sample per cycle.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, empties the pipe
//   bus   : sm_const_mult_pipe_if.slave (in/out valid-ready streams, out_sat)
// Build option:
//   SM_CMUL_ROUND_EN : terms are accumulated as exact fixed point and the
//                      result is rounded to nearest (ties up); default build
//                      sums individually floored terms.
// Results above 2^(WIDTH-1)-1 clamp to all ones with out_sat=1; a zero
// magnitude always leaves with sign 0.
module sm_const_mult_pipe #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] COEF_MASK = 32'hFBA9_C0E4,
  parameter int               STAGES    = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sm_const_mult_pipe_if.slave  bus
);
  localparam int MAG_W = WIDTH - 1;
  localparam int CW    = $clog2(WIDTH + 1);
`ifdef SM_CMUL_ROUND_EN
  // Binary point sits MAG_W bits up so every term is exact.
  localparam int ACC_W = 2 * MAG_W + CW;
`else
  localparam int ACC_W = MAG_W + CW;
`endif

  typedef logic [ACC_W-1:0] acc_t;

  // Sum of the terms owned by stage s; the mask and stage are constants,
  // so this collapses to a fixed shift-add tree per stage.
  function automatic acc_t stage_sum(input logic [MAG_W-1:0] m, input int s);
    acc_t sum;
    sum = '0;
    for (int k = 0; k < MAG_W; k++)
      if (COEF_MASK[k] && ((k * STAGES) / WIDTH == s))
`ifdef SM_CMUL_ROUND_EN
        sum = sum + (acc_t'(m) << (MAG_W - k));
`else
        sum = sum + (acc_t'(m) >> k);
`endif
    return sum;
  endfunction

  logic [STAGES-1:0] vld_pipe;
  logic              adv;

  assign adv          = !vld_pipe[STAGES-1] || bus.out_ready;
  assign bus.in_ready = adv;

  // Bubbles shift along with data; nothing moves while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   vld_pipe <= '0;
    else if (adv) vld_pipe <= (vld_pipe << 1) | STAGES'(bus.in_valid);
  end

  for (genvar s = 0; s < STAGES; s++) begin : g_stg
    acc_t             acc_i;
    logic             sgn_i;
    logic [MAG_W-1:0] mag_i;
    acc_t             acc_q;
    logic             sgn_q;

    if (s == 0) begin : g_src
      assign acc_i = '0;
      assign sgn_i = bus.in_data[WIDTH-1];
      assign mag_i = bus.in_data[MAG_W-1:0];
    end else begin : g_src
      assign acc_i = g_stg[s-1].acc_q;
      assign sgn_i = g_stg[s-1].sgn_q;
      assign mag_i = g_stg[s-1].g_mag.mag_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        acc_q <= '0;
        sgn_q <= 1'b0;
      end else if (adv) begin
        acc_q <= acc_i + stage_sum(mag_i, s);
        sgn_q <= sgn_i;
      end
    end

    // The last stage has no consumer for the magnitude.
    if (s < STAGES - 1) begin : g_mag
      logic [MAG_W-1:0] mag_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   mag_q <= '0;
        else if (adv) mag_q <= mag_i;
      end
    end
  end

  acc_t             res;
  logic             sat;
  logic [MAG_W-1:0] mag_o;

`ifdef SM_CMUL_ROUND_EN
  acc_t rnd;
  assign rnd = g_stg[STAGES-1].acc_q + (acc_t'(1) << (MAG_W - 1));
  assign res = rnd >> MAG_W;
`else
  assign res = g_stg[STAGES-1].acc_q;
`endif

  // Output is decoded from the frozen last-stage register, so it holds
  // steady under backpressure and reads as zero straight out of reset.
  assign sat           = |res[ACC_W-1:MAG_W];
  assign mag_o         = sat ? {MAG_W{1'b1}} : res[MAG_W-1:0];
  assign bus.out_valid = vld_pipe[STAGES-1];
  assign bus.out_sat   = sat;
  assign bus.out_data  = {g_stg[STAGES-1].sgn_q & (|mag_o), mag_o};
endmodule

// File: tb/tb_sm_const_mult_pipe.sv
module tb_sm_const_mult_pipe;
  localparam int NDUT = 4;
  localparam logic [31:0] DEF_MASK = 32'hFBA9_C0E4;
  localparam int          STG [NDUT] = '{4, 4, 1, 32};
  localparam logic [31:0] MSK [NDUT] = '{DEF_MASK, 32'h0000_0003, DEF_MASK, DEF_MASK};
`ifdef SM_CMUL_ROUND_EN
  localparam logic [32:0] NZ_EXP = 33'h0_8000_0001;
`else
  localparam logic [32:0] NZ_EXP = 33'h0_0000_0000;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        drv_valid [NDUT];
  logic        drv_ready [NDUT];
  logic [31:0] drv_data  [NDUT];
  logic        mon_ir    [NDUT];
  logic        mon_ov    [NDUT];
  logic        mon_sat   [NDUT];
  logic [31:0] mon_od    [NDUT];

  for (genvar i = 0; i < NDUT; i++) begin : g_dut
    sm_const_mult_pipe_if #(.WIDTH(32)) bus ();
    assign bus.in_valid  = drv_valid[i];
    assign bus.in_data   = drv_data[i];
    assign bus.out_ready = drv_ready[i];
    assign mon_ir[i]     = bus.in_ready;
    assign mon_ov[i]     = bus.out_valid;
    assign mon_od[i]     = bus.out_data;
    assign mon_sat[i]    = bus.out_sat;
    sm_const_mult_pipe #(.WIDTH(32), .COEF_MASK(MSK[i]), .STAGES(STG[i])) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int i, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %h expected %h", nm, i, act, exp);
    end
  endtask

  // Reference: straight arithmetic on one operand, {sat, sign, magnitude}.
  function automatic logic [32:0] ref_mult(input logic [31:0] x, input logic [31:0] mask);
    logic [95:0] acc;
    logic [95:0] q;
    logic [30:0] mag;
    logic        sat;
    acc = '0;
    for (int k = 0; k < 31; k++)
      if (mask[k]) begin
`ifdef SM_CMUL_ROUND_EN
        acc = acc + ({65'd0, x[30:0]} << (31 - k));
`else
        acc = acc + {65'd0, x[30:0] >> k};
`endif
      end
`ifdef SM_CMUL_ROUND_EN
    q = (acc + (96'd1 << 30)) >> 31;
`else
    q = acc;
`endif
    sat = (q > 96'h7FFF_FFFF);
    mag = sat ? 31'h7FFF_FFFF : q[30:0];
    return {sat, x[31] && (mag != 0), mag};
  endfunction

  // Scoreboard rings, one per DUT; pushed on accept, popped on output transfer.
  logic [32:0] sb [NDUT][64];
  int wr_p [NDUT];
  int rd_p [NDUT];
  int acc_cnt [NDUT];
  int out_cnt [NDUT];

  always @(negedge clk) begin
    for (int i = 0; i < NDUT; i++) begin
      if (!rst_n) begin
        wr_p[i] = 0; rd_p[i] = 0; acc_cnt[i] = 0; out_cnt[i] = 0;
      end else begin
        chk("in_ready", i, mon_ir[i], !mon_ov[i] || drv_ready[i]);
        if (mon_ov[i]) begin
          if (wr_p[i] == rd_p[i]) chk("stray_out_valid", i, mon_ov[i], 1'b0);
          else begin
            chk("out_data", i, {mon_sat[i], mon_od[i]}, sb[i][rd_p[i] % 64]);
            if (drv_ready[i]) begin rd_p[i]++; out_cnt[i]++; end
          end
        end
        if (drv_valid[i] && mon_ir[i]) begin
          sb[i][wr_p[i] % 64] = ref_mult(drv_data[i], MSK[i]);
          wr_p[i]++; acc_cnt[i]++;
        end
      end
    end
  end

  // Called at posedge+1 with an idle pipe; measures edges until out_valid.
  task automatic send_chk(input int i, input logic [31:0] d, input logic [32:0] exp);
    bit got = 0;
    drv_valid[i] = 1'b1;
    drv_data[i]  = d;
    for (int lat = 1; lat <= 60 && !got; lat++) begin
      @(posedge clk); #1;
      if (lat == 1) drv_valid[i] = 1'b0;
      @(negedge clk);
      if (mon_ov[i]) begin
        got = 1;
        chk("latency", i, lat, STG[i]);
        chk("direct", i, {mon_sat[i], mon_od[i]}, exp);
      end
    end
    if (!got) chk("direct_timeout", i, got, 1'b1);
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] rnd_data();
    logic [31:0] v = $urandom;
    case ($urandom_range(0, 7))
      0: v = 32'h0000_0000;
      1: v = 32'h8000_0000;
      2: v = 32'h7FFF_FFFF;
      3: v = 32'hFFFF_FFFF;
      4: v = v & 32'h8000_000F;
      default: ;
    endcase
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] bp [6];
    int base_a, base_o, n;
    for (int i = 0; i < NDUT; i++) begin
      drv_valid[i] = 1'b0; drv_ready[i] = 1'b1; drv_data[i] = '0;
    end
    #1 rst_n = 1'b0;

    // Pin the model against hand-worked values.
    chk("model_pos",    0, ref_mult(32'h0000_0400, DEF_MASK), 33'h0_0000_0138);
    chk("model_neg",    0, ref_mult(32'h8000_0400, DEF_MASK), 33'h0_8000_0138);
    chk("model_negzero",0, ref_mult(32'h8000_0003, DEF_MASK), NZ_EXP);
    chk("model_sat",    1, ref_mult(32'h7FFF_FFFF, 32'h3),    33'h1_7FFF_FFFF);
    chk("model_x1p5",   1, ref_mult(32'h0000_0010, 32'h3),    33'h0_0000_0018);
    chk("model_mask0",  0, ref_mult(32'hFFFF_FFFF, 32'h0),    33'h0_0000_0000);

    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < NDUT; i++)
      chk("reset_out", i, {mon_ov[i], mon_sat[i], mon_od[i]}, '0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    send_chk(0, 32'h0000_0400, 33'h0_0000_0138);
    send_chk(0, 32'h8000_0400, 33'h0_8000_0138);
    send_chk(0, 32'h8000_0003, NZ_EXP);
    send_chk(1, 32'h7FFF_FFFF, 33'h1_7FFF_FFFF);
    send_chk(1, 32'h0000_0010, 33'h0_0000_0018);
    send_chk(2, 32'h0000_0400, 33'h0_0000_0138);
    send_chk(3, 32'h8000_0400, 33'h0_8000_0138);

    // Backpressure: 10 stalled cycles while offering 6 samples.
    for (int j = 0; j < 6; j++) bp[j] = rnd_data();
    base_a = acc_cnt[0];
    base_o = out_cnt[0];
    drv_ready[0] = 1'b0;
    for (int c = 0; c < 10; c++) begin
      n = acc_cnt[0] - base_a;
      drv_valid[0] = (n < 6);
      if (n < 6) drv_data[0] = bp[n];
      @(posedge clk); #1;
    end
    chk("bp_accepted", 0, acc_cnt[0] - base_a, 4);
    chk("bp_in_ready", 0, mon_ir[0], 1'b0);
    drv_ready[0] = 1'b1;
    for (int c = 0; c < 60 && (out_cnt[0] - base_o) < 6; c++) begin
      n = acc_cnt[0] - base_a;
      drv_valid[0] = (n < 6);
      if (n < 6) drv_data[0] = bp[n];
      @(posedge clk); #1;
    end
    drv_valid[0] = 1'b0;
    chk("bp_accept_total", 0, acc_cnt[0] - base_a, 6);
    chk("bp_emitted", 0, out_cnt[0] - base_o, 6);

    // Reset with samples in flight.
    for (int c = 0; c < 3; c++) begin
      drv_valid[0] = 1'b1; drv_data[0] = rnd_data();
      drv_valid[2] = 1'b1; drv_data[2] = rnd_data();
      drv_valid[3] = 1'b1; drv_data[3] = rnd_data();
      @(posedge clk); #1;
    end
    for (int i = 0; i < NDUT; i++) drv_valid[i] = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < NDUT; i++)
      chk("reset_async", i, {mon_ov[i], mon_sat[i], mon_od[i]}, '0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    for (int i = 0; i < NDUT; i++) chk("post_reset_stale", i, out_cnt[i], 0);

    // Random soak on all configurations.
    for (int c = 0; c < 6000; c++) begin
      for (int i = 0; i < NDUT; i++) begin
        drv_valid[i] = ($urandom_range(0, 3) != 0);
        drv_data[i]  = rnd_data();
        drv_ready[i] = ($urandom_range(0, 4) != 0);
      end
      @(posedge clk); #1;
    end
    for (int i = 0; i < NDUT; i++) begin
      drv_valid[i] = 1'b0; drv_ready[i] = 1'b1;
    end
    repeat (80) @(posedge clk);
    #1;
    for (int i = 0; i < NDUT; i++) begin
      chk("drain_empty", i, wr_p[i] - rd_p[i], 0);
      chk("soak_traffic", i, (acc_cnt[i] > 1000), 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
